mc_ctrl_fsm: RTL and testbench

Parametrised multicycle main control FSM for the ARM-subset core. It is the successor to the fixed 13-bit-control FSM.
- Sequences fetch, decode, memory, ALU and branch states.
- Adds a handshaked multiply/divide execute phase with fixed-latency or done-driven completion.
- Adds dual writeback (RdLo then RdHi) for long multiply.
- Adds an optional memory wait-state handshake.
- Sits between the instruction decoder and the datapath mux/enable inputs.

---
 rtl/mc_ctrl_pkg.sv | 57 +++++
 rtl/mc_md_timer.sv | 44 ++++
 rtl/mc_ctrl_fsm.sv | 181 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mc_ctrl_pkg : state encoding, opcode/result codes and control bundle
// Rev 1.0
// ============================================================================
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_MD_EXEC = 4'd10,
    S_MD_WBLO = 4'd11,
    S_MD_WBHI = 4'd12,
    S_UNKNOWN = 4'd13
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_MD     = 2'b11;

  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       wb_hi;
    logic       illegal;
    logic       busy_md;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage
`default_nettype wire

// File: rtl/mc_md_timer.sv
`default_nettype none
// ============================================================================
// mc_md_timer : mul/div latency counter, start pulse and completion detect
// Rev 1.0
// ============================================================================
module mc_md_timer #(
  parameter int MD_FIXED_LAT = 0,
  parameter int MD_CNT_W     = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enter,
  input  logic i_active,
  input  logic i_md_done,
  output logic o_md_start,
  output logic o_done
);

  localparam int                  c_last_i = (MD_FIXED_LAT > 0) ? MD_FIXED_LAT - 1 : 0;
  localparam logic [MD_CNT_W-1:0] c_last   = MD_CNT_W'(c_last_i);

  logic [MD_CNT_W-1:0] r_cnt;
  logic                r_first;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else begin
      r_first <= i_enter;
      if (i_enter) begin
        r_cnt <= '0;
      end else if (i_active && (r_cnt != '1)) begin
        // saturate so a long stall can never alias back to an early count
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_md_start = r_first & i_active;
  assign o_done     = (MD_FIXED_LAT == 0) ? i_md_done : (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// mc_ctrl_fsm : multicycle main control FSM with mul/div execute and dual
// writeback. Define MC_CTRL_MEM_WAIT_EN for the mem_ready wait-state handshake.
// Rev 1.0
// ============================================================================
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MD_FIXED_LAT = 0,
  parameter int MD_CNT_W     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       is_mul,
  input  logic       is_div,
  input  logic       is_long,
  input  logic       md_done,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       ir_write,
  output logic       adr_src,
  output logic       next_pc,
  output logic       reg_w,
  output logic       mem_w,
  output logic       branch,
  output logic       alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       md_start,
  output logic       wb_hi,
  output logic       illegal,
  output logic       busy_md
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  logic   r_long;
  logic   w_mem_rdy;
  logic   w_md_done;
  logic   w_md_start;
  logic   w_enter;
  logic   w_unused;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign w_mem_rdy = mem_ready;
`else
  assign w_mem_rdy = 1'b1;
`endif

  assign w_unused = &{1'b0, funct[4:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_long <= (op == OP_DP) & is_mul & is_long;
      end
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_DP:   w_next = is_mul ? S_MD_EXEC : (funct[5] ? S_EXECI : S_EXECR);
          OP_MEM:  w_next = is_div ? S_MD_EXEC : S_MEMADR;
          OP_BR:   w_next = S_BRANCH;
          default: w_next = S_UNKNOWN;
        endcase
      end
      S_MEMADR:  w_next = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = w_mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = w_mem_rdy ? S_FETCH : S_MEMWR;
      S_EXECR:   w_next = S_ALUWB;
      S_EXECI:   w_next = S_ALUWB;
      S_ALUWB:   w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_MD_EXEC: w_next = w_md_done ? S_MD_WBLO : S_MD_EXEC;
      S_MD_WBLO: w_next = r_long ? S_MD_WBHI : S_FETCH;
      S_MD_WBHI: w_next = S_FETCH;
      S_UNKNOWN: w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl = CTRL_IDLE;
    case (r_state)
      S_FETCH: begin
        w_ctrl.ir_write   = w_mem_rdy;
        w_ctrl.next_pc    = w_mem_rdy;
        w_ctrl.result_src = RES_ALU;
        w_ctrl.alu_src_a  = SRCA_PC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
      end
      S_DECODE: begin
        w_ctrl.result_src = RES_ALU;
        w_ctrl.alu_src_a  = SRCA_PC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
      end
      S_MEMADR: w_ctrl.alu_src_b = SRCB_IMM;
      S_MEMRD:  w_ctrl.adr_src   = 1'b1;
      S_MEMWB: begin
        w_ctrl.reg_w      = 1'b1;
        w_ctrl.result_src = RES_DATA;
      end
      S_MEMWR: begin
        w_ctrl.mem_w   = 1'b1;
        w_ctrl.adr_src = 1'b1;
      end
      S_EXECR: w_ctrl.alu_op = 1'b1;
      S_EXECI: begin
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = 1'b1;
      end
      S_ALUWB: w_ctrl.reg_w = 1'b1;
      S_BRANCH: begin
        w_ctrl.branch     = 1'b1;
        w_ctrl.result_src = RES_ALU;
        w_ctrl.alu_src_b  = SRCB_IMM;
      end
      S_MD_EXEC: w_ctrl.busy_md = 1'b1;
      S_MD_WBLO: begin
        w_ctrl.reg_w      = 1'b1;
        w_ctrl.result_src = RES_MD;
      end
      S_MD_WBHI: begin
        w_ctrl.reg_w      = 1'b1;
        w_ctrl.result_src = RES_MD;
        w_ctrl.wb_hi      = 1'b1;
      end
      S_UNKNOWN: w_ctrl.illegal = 1'b1;
      default:   w_ctrl = CTRL_IDLE;
    endcase
  end

  assign w_enter = (r_state == S_DECODE) && (w_next == S_MD_EXEC);

  mc_md_timer #(
    .MD_FIXED_LAT (MD_FIXED_LAT),
    .MD_CNT_W     (MD_CNT_W)
  ) u_md_timer (
    .clk        (clk),
    .reset      (reset),
    .i_enter    (w_enter),
    .i_active   (r_state == S_MD_EXEC),
    .i_md_done  (md_done),
    .o_md_start (w_md_start),
    .o_done     (w_md_done)
  );

  // reset is asynchronous, so enables are masked combinationally while it is high
  assign ir_write   = w_ctrl.ir_write & ~reset;
  assign next_pc    = w_ctrl.next_pc  & ~reset;
  assign reg_w      = w_ctrl.reg_w    & ~reset;
  assign mem_w      = w_ctrl.mem_w    & ~reset;
  assign branch     = w_ctrl.branch   & ~reset;
  assign illegal    = w_ctrl.illegal  & ~reset;
  assign md_start   = w_md_start      & ~reset;
  assign adr_src    = w_ctrl.adr_src;
  assign alu_op     = w_ctrl.alu_op;
  assign alu_src_a  = w_ctrl.alu_src_a;
  assign alu_src_b  = w_ctrl.alu_src_b;
  assign result_src = w_ctrl.result_src;
  assign wb_hi      = w_ctrl.wb_hi;
  assign busy_md    = w_ctrl.busy_md;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// tb_mc_ctrl_fsm : directed bench for mc_ctrl_fsm (done-driven and fixed-latency)
// Rev 1.0
// ============================================================================
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [1:0] op;
  logic [5:0] funct;
  logic       is_mul, is_div, is_long;
  logic       md_done_a;
  logic       md_done_b;
  logic       sel;
`ifdef MC_CTRL_MEM_WAIT_EN
  logic       mem_ready;
`endif

  logic       ir_a, adr_a, npc_a, rw_a, mw_a, br_a, aop_a, ms_a, hi_a, il_a, bz_a;
  logic [1:0] sa_a, sb_a, rs_a;
  logic       ir_b, adr_b, npc_b, rw_b, mw_b, br_b, aop_b, ms_b, hi_b, il_b, bz_b;
  logic [1:0] sa_b, sb_b, rs_b;
  logic [16:0] ctl_a, ctl_b;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt = 0, ms_cnt = 0, hi_cnt = 0, mw_cnt = 0, il_cnt = 0;
  int last_len;
  logic [16:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MD_FIXED_LAT(0), .MD_CNT_W(6)) u_dut_a (
    .clk(clk), .reset(rst_a), .op(op), .funct(funct),
    .is_mul(is_mul), .is_div(is_div), .is_long(is_long), .md_done(md_done_a),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .ir_write(ir_a), .adr_src(adr_a), .next_pc(npc_a), .reg_w(rw_a), .mem_w(mw_a),
    .branch(br_a), .alu_op(aop_a), .alu_src_a(sa_a), .alu_src_b(sb_a),
    .result_src(rs_a), .md_start(ms_a), .wb_hi(hi_a), .illegal(il_a), .busy_md(bz_a)
  );

  mc_ctrl_fsm #(.MD_FIXED_LAT(3), .MD_CNT_W(6)) u_dut_b (
    .clk(clk), .reset(rst_b), .op(op), .funct(funct),
    .is_mul(is_mul), .is_div(is_div), .is_long(is_long), .md_done(md_done_b),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .ir_write(ir_b), .adr_src(adr_b), .next_pc(npc_b), .reg_w(rw_b), .mem_w(mw_b),
    .branch(br_b), .alu_op(aop_b), .alu_src_a(sa_b), .alu_src_b(sb_b),
    .result_src(rs_b), .md_start(ms_b), .wb_hi(hi_b), .illegal(il_b), .busy_md(bz_b)
  );

  assign ctl_a = {ir_a, adr_a, npc_a, rw_a, mw_a, br_a, aop_a, sa_a, sb_a, rs_a, ms_a, hi_a, il_a, bz_a};
  assign ctl_b = {ir_b, adr_b, npc_b, rw_b, mw_b, br_b, aop_b, sa_b, sb_b, rs_b, ms_b, hi_b, il_b, bz_b};

  // Expected control word for a named step, straight from the control table
  function automatic logic [16:0] exp_ctl(input string st);
    logic ir, adr, npc, rw, mw, br, aop, ms, hi, il, bz;
    logic [1:0] sa, sb, rs;
    {ir, adr, npc, rw, mw, br, aop, ms, hi, il, bz} = '0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00;
    case (st)
      "FETCH":      begin ir = 1; npc = 1; rs = 2'b10; sa = 2'b01; sb = 2'b10; end
      "FETCH_WAIT": begin rs = 2'b10; sa = 2'b01; sb = 2'b10; end
      "RESET":      begin rs = 2'b10; sa = 2'b01; sb = 2'b10; end
      "DECODE":     begin rs = 2'b10; sa = 2'b01; sb = 2'b10; end
      "MEMADR":     sb = 2'b01;
      "MEMRD":      adr = 1;
      "MEMWB":      begin rw = 1; rs = 2'b01; end
      "MEMWR":      begin mw = 1; adr = 1; end
      "EXECR":      aop = 1;
      "EXECI":      begin sb = 2'b01; aop = 1; end
      "ALUWB":      rw = 1;
      "BRANCH":     begin br = 1; rs = 2'b10; sb = 2'b01; end
      "MD_START":   begin ms = 1; bz = 1; end
      "MD_EXEC":    bz = 1;
      "MD_WBLO":    begin rw = 1; rs = 2'b11; end
      "MD_WBHI":    begin rw = 1; rs = 2'b11; hi = 1; end
      "UNKNOWN":    il = 1;
      default:      ;
    endcase
    return {ir, adr, npc, rw, mw, br, aop, sa, sb, rs, ms, hi, il, bz};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic cmp_cycle();
    logic [16:0] got;
    got = sel ? ctl_b : ctl_a;
    if (exp_q.size() > 0) check(name_q.pop_front(), {15'd0, got}, {15'd0, exp_q.pop_front()});
    busy_cnt += int'(got[0]);
    il_cnt   += int'(got[1]);
    hi_cnt   += int'(got[2]);
    ms_cnt   += int'(got[3]);
    mw_cnt   += int'(got[12]);
  endtask

  // Runs one instruction from its FETCH cycle (called at posedge+1 in FETCH).
  // md_len: MD_EXEC cycles expected; abort_at: step index at which reset hits (-1 none).
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic m,
                           input logic d, input logic lng, input int md_len,
                           input int abort_at, input int fetch_wait);
    string seq[$];
    int    n, done_idx;
    for (int i = 0; i < fetch_wait; i++) seq.push_back("FETCH_WAIT");
    seq.push_back("FETCH");
    seq.push_back("DECODE");
    done_idx = -1;
    if ((o == 2'b00 && m) || (o == 2'b01 && d)) begin
      done_idx = fetch_wait + 2 + md_len - 1;
      for (int i = 0; i < md_len; i++) begin
        if (i == 0) seq.push_back("MD_START");
        else        seq.push_back("MD_EXEC");
      end
      seq.push_back("MD_WBLO");
      if (o == 2'b00 && lng) seq.push_back("MD_WBHI");
    end else if (o == 2'b00) begin
      if (f[5]) seq.push_back("EXECI");
      else      seq.push_back("EXECR");
      seq.push_back("ALUWB");
    end else if (o == 2'b01) begin
      seq.push_back("MEMADR");
      if (f[0]) begin seq.push_back("MEMRD"); seq.push_back("MEMWB"); end
      else      seq.push_back("MEMWR");
    end else if (o == 2'b10) begin
      seq.push_back("BRANCH");
    end else begin
      seq.push_back("UNKNOWN");
    end
    last_len = seq.size();
    n = (abort_at >= 0) ? abort_at + 1 : seq.size();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(exp_ctl(seq[k]));
      name_q.push_back($sformatf("%s@%0d op=%b", seq[k], k, o));
    end
    op = o; funct = f; is_mul = m; is_div = d; is_long = lng;
    for (int k = 0; k < n; k++) begin
      md_done_a = (k == done_idx);
`ifdef MC_CTRL_MEM_WAIT_EN
      mem_ready = (k >= fetch_wait);
`endif
      if (abort_at >= 0 && k == n - 1) break;
      @(posedge clk); #1;
    end
    md_done_a = 1'b0;
    if (abort_at >= 0) begin
      @(negedge clk); #1;
      rst_a = 1'b1;
      #1;
      check("abort_regw_now", {31'd0, rw_a}, 32'd0);
      check("abort_ctl_now", {15'd0, ctl_a}, {15'd0, exp_ctl("RESET")});
      @(posedge clk); #1;
      check("abort_ctl_held", {15'd0, ctl_a}, {15'd0, exp_ctl("RESET")});
      rst_a = 1'b0;
    end
  endtask

  initial begin
    int b_busy, b_ms, b_hi, b_mw, b_il;
    rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
    op = 2'b00; funct = 6'd0; is_mul = 0; is_div = 0; is_long = 0;
    md_done_a = 0; md_done_b = 0;
`ifdef MC_CTRL_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    fork
      forever begin
        @(negedge clk);
        cmp_cycle();
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("reset_a", {15'd0, ctl_a}, {15'd0, exp_ctl("RESET")});
    check("reset_b", {15'd0, ctl_b}, {15'd0, exp_ctl("RESET")});
    rst_a = 1'b0;

    // ALU immediate / register
    run_instr(2'b00, 6'b101000, 0, 0, 0, 0, -1, 0);
    check("add_imm_len", last_len, 4);
    run_instr(2'b00, 6'b001000, 0, 0, 0, 0, -1, 0);

    // loads/stores
    run_instr(2'b01, 6'b011001, 0, 0, 0, 0, -1, 0);
    b_mw = mw_cnt;
    run_instr(2'b01, 6'b011000, 0, 0, 0, 0, -1, 0);
    check("str_memw_cycles", mw_cnt - b_mw, 1);

    // branch, undefined op, decoder flags ignored for other ops
    run_instr(2'b10, 6'b000000, 0, 0, 0, 0, -1, 0);
    b_il = il_cnt;
    run_instr(2'b11, 6'b111111, 0, 0, 0, 0, -1, 0);
    check("illegal_cycles", il_cnt - b_il, 1);
    run_instr(2'b01, 6'b000001, 1, 0, 1, 0, -1, 0);
    run_instr(2'b10, 6'b000000, 1, 1, 1, 0, -1, 0);

    // long multiply, done in 6th MD_EXEC cycle
    b_busy = busy_cnt; b_ms = ms_cnt; b_hi = hi_cnt;
    run_instr(2'b00, 6'b000000, 1, 0, 1, 6, -1, 0);
    check("mul_busy_cycles", busy_cnt - b_busy, 6);
    check("mul_start_pulses", ms_cnt - b_ms, 1);
    check("mul_hi_wb", hi_cnt - b_hi, 1);

    // single-cycle unit, and divide with is_long set (no high writeback)
    run_instr(2'b00, 6'b000000, 1, 0, 0, 1, -1, 0);
    b_hi = hi_cnt;
    run_instr(2'b01, 6'b000000, 0, 1, 1, 2, -1, 0);
    check("div_no_hi", hi_cnt - b_hi, 0);

    // reset mid MD_WBLO, then normal execution resumes from FETCH
    b_hi = hi_cnt;
    run_instr(2'b00, 6'b000000, 1, 0, 1, 2, 4, 0);
    run_instr(2'b00, 6'b101000, 0, 0, 0, 0, -1, 0);
    check("abort_no_hi", hi_cnt - b_hi, 0);

    // fixed-latency instance
    rst_a = 1'b1; rst_b = 1'b0; sel = 1'b1;
    b_busy = busy_cnt; b_ms = ms_cnt;
    run_instr(2'b01, 6'b000000, 0, 1, 0, 3, -1, 0);
    check("fix_busy_cycles", busy_cnt - b_busy, 3);
    check("fix_start_pulses", ms_cnt - b_ms, 1);
    b_hi = hi_cnt;
    run_instr(2'b00, 6'b000000, 1, 0, 1, 3, -1, 0);
    check("fix_long_hi", hi_cnt - b_hi, 1);
    run_instr(2'b00, 6'b100000, 0, 0, 0, 0, -1, 0);
`ifdef MC_CTRL_MEM_WAIT_EN
    run_instr(2'b00, 6'b101000, 0, 0, 0, 0, -1, 3);
    run_instr(2'b01, 6'b000001, 0, 0, 0, 0, -1, 0);
`endif
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
